// File: rtl/known_sink_table_update.sv
// Scans the knownSinks table for sink_id and inserts it into the first empty slot,
// reporting inserted / duplicate / table_full. One entry compared per clock.
module known_sink_table_update #(
   parameter int                  WORD_WIDTH = 16,
   parameter logic [WORD_WIDTH-1:0] SINK_BASE = 16'h0008,
   parameter int                  NUM_SINKS  = 16,
   parameter logic [WORD_WIDTH-1:0] EMPTY_ID  = 16'hFFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] sink_id,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [WORD_WIDTH-1:0] address,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  wr_en,
   output logic                  done,
   output logic                  inserted,
   output logic                  duplicate,
   output logic                  table_full
);

   // state  | meaning
   // IDLE   | waiting for start
   // SCAN   | comparing one table entry per clock
   // WRITE  | single write cycle into the recorded free slot
   // DONE   | holding done/flags until start drops
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

   localparam int IDX_W = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SINKS - 1);

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] id_q, id_d;
   logic [IDX_W-1:0]      j_q, j_d;
   logic [IDX_W-1:0]      free_idx_q, free_idx_d;
   logic                  free_vld_q, free_vld_d;
   logic [WORD_WIDTH-1:0] address_q, address_d;
   logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
   logic                  wr_en_q, wr_en_d;
   logic                  done_q, done_d;
   logic                  inserted_q, inserted_d;
   logic                  duplicate_q, duplicate_d;
   logic                  table_full_q, table_full_d;
   logic                  rec_vld;
   logic [IDX_W-1:0]      rec_idx;

   function automatic logic [WORD_WIDTH-1:0] slot_addr(input logic [WORD_WIDTH-1:0] idx);
      return SINK_BASE + (idx << 1);
   endfunction

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      j_d          = j_q;
      free_idx_d   = free_idx_q;
      free_vld_d   = free_vld_q;
      address_d    = address_q;
      data_out_d   = data_out_q;
      wr_en_d      = wr_en_q;
      done_d       = done_q;
      inserted_d   = inserted_q;
      duplicate_d  = duplicate_q;
      table_full_d = table_full_q;
      rec_vld      = free_vld_q;
      rec_idx      = free_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               id_d       = sink_id;
               j_d        = '0;
               free_vld_d = 1'b0;
               free_idx_d = '0;
               address_d  = SINK_BASE;
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            if (id_q == EMPTY_ID) begin
               // the empty marker is never recorded as a sink
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (data_in == id_q) begin
               duplicate_d = 1'b1;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end else begin
               if ((data_in == EMPTY_ID) && !free_vld_q) begin
                  rec_vld = 1'b1;
                  rec_idx = j_q;
               end
               free_vld_d = rec_vld;
               free_idx_d = rec_idx;
               if (j_q == LAST_IDX) begin
                  if (rec_vld) begin
                     address_d  = slot_addr(WORD_WIDTH'(rec_idx));
                     data_out_d = id_q;
                     wr_en_d    = 1'b1;
                     state_d    = S_WRITE;
                  end else begin
                     table_full_d = 1'b1;
                     done_d       = 1'b1;
                     state_d      = S_DONE;
                  end
               end else begin
                  j_d       = j_q + 1'b1;
                  address_d = slot_addr(WORD_WIDTH'(j_q) + 1'b1);
               end
            end
         end
         S_WRITE: begin
            wr_en_d    = 1'b0;
            inserted_d = 1'b1;
            done_d     = 1'b1;
            address_d  = SINK_BASE;
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (!start) begin
               done_d       = 1'b0;
               inserted_d   = 1'b0;
               duplicate_d  = 1'b0;
               table_full_d = 1'b0;
               address_d    = SINK_BASE;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         id_q         <= '0;
         j_q          <= '0;
         free_idx_q   <= '0;
         free_vld_q   <= 1'b0;
         address_q    <= SINK_BASE;
         data_out_q   <= '0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
         inserted_q   <= 1'b0;
         duplicate_q  <= 1'b0;
         table_full_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         j_q          <= j_d;
         free_idx_q   <= free_idx_d;
         free_vld_q   <= free_vld_d;
         address_q    <= address_d;
         data_out_q   <= data_out_d;
         wr_en_q      <= wr_en_d;
         done_q       <= done_d;
         inserted_q   <= inserted_d;
         duplicate_q  <= duplicate_d;
         table_full_q <= table_full_d;
      end
   end

   assign address    = address_q;
   assign data_out   = data_out_q;
   assign wr_en      = wr_en_q;
   assign done       = done_q;
   assign inserted   = inserted_q;
   assign duplicate  = duplicate_q;
   assign table_full = table_full_q;

endmodule

// File: tb/tb_known_sink_table_update.sv
// Bench for known_sink_table_update: behavioural table memory plus an expected-result queue.
module tb_known_sink_table_update;

   localparam logic [15:0] BASE  = 16'h0008;
   localparam logic [15:0] EMPTY = 16'hFFFF;

   logic        clock, reset, start;
   logic [15:0] sink_id, data_in, address, data_out;
   logic        wr_en, done, inserted, duplicate, table_full;

   typedef struct {
      int          lat;
      logic        ins, dup, full;
      int          nwr;
      logic [15:0] waddr, wdata;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem[16];
   int          wr_cnt;
   logic [15:0] wr_addr, wr_data;
   int          n_cmp, n_fail;

   known_sink_table_update dut (
      .clock(clock), .reset(reset), .start(start), .sink_id(sink_id),
      .data_in(data_in), .address(address), .data_out(data_out), .wr_en(wr_en),
      .done(done), .inserted(inserted), .duplicate(duplicate), .table_full(table_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [15:0] rd_off;
   assign rd_off  = address - BASE;
   assign data_in = (rd_off < 16'd32) ? mem[rd_off[4:1]] : 16'h0000;

   always @(negedge clock) begin
      if (wr_en) begin
         if (rd_off < 16'd32) mem[rd_off[4:1]] = data_out;
         wr_cnt  = wr_cnt + 1;
         wr_addr = address;
         wr_data = data_out;
      end
   end

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 16; i++) mem[i] = v;
   endtask

   task automatic run_op(input logic [15:0] id, input bit pulse, input int hold_extra, input exp_t e);
      int   cyc;
      bit   got;
      exp_t x;
      sb.push_back(e);
      wr_cnt = 0;
      @(negedge clock);
      sink_id = id;
      start   = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if (address !== BASE) begin
         n_fail++; $display("FAIL first_addr id=%h got %h want %h", id, address, BASE);
      end
      if (pulse) begin @(negedge clock); start = 1'b0; end
      cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
         if (done === 1'b1) got = 1;
      end
      x = sb.pop_front();
      n_cmp++;
      if (!got) begin
         n_fail++; $display("FAIL done_timeout id=%h got none want done at E%0d", id, x.lat);
      end else begin
         if (cyc !== x.lat) begin
            n_fail++; $display("FAIL latency id=%h got E%0d want E%0d", id, cyc, x.lat);
         end
         n_cmp++;
         if ({inserted, duplicate, table_full} !== {x.ins, x.dup, x.full}) begin
            n_fail++; $display("FAIL flags id=%h got %b want %b", id,
                               {inserted, duplicate, table_full}, {x.ins, x.dup, x.full});
         end
         n_cmp++;
         if (wr_cnt !== x.nwr) begin
            n_fail++; $display("FAIL write_count id=%h got %0d want %0d", id, wr_cnt, x.nwr);
         end
         if (x.nwr == 1) begin
            n_cmp++;
            if ({wr_addr, wr_data} !== {x.waddr, x.wdata}) begin
               n_fail++; $display("FAIL write_beat id=%h got %h/%h want %h/%h", id,
                                  wr_addr, wr_data, x.waddr, x.wdata);
            end
         end
      end
      for (int i = 0; i < hold_extra; i++) begin
         @(posedge clock); #1;
         n_cmp++;
         if ({done, inserted, duplicate, table_full} !== {1'b1, x.ins, x.dup, x.full}) begin
            n_fail++; $display("FAIL done_hold id=%h got %b want %b", id,
                               {done, inserted, duplicate, table_full}, {1'b1, x.ins, x.dup, x.full});
         end
      end
      if (!pulse) begin @(negedge clock); start = 1'b0; end
      @(posedge clock); #1;
      n_cmp++;
      if ({done, inserted, duplicate, table_full, wr_en} !== 5'b0 || address !== BASE) begin
         n_fail++; $display("FAIL release id=%h got done/flags/wr=%b addr=%h want 00000 addr=%h",
                            id, {done, inserted, duplicate, table_full, wr_en}, address, BASE);
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (address !== BASE || data_out !== 16'h0 ||
          {wr_en, done, inserted, duplicate, table_full} !== 5'b0) begin
         n_fail++; $display("FAIL reset_state got addr=%h dout=%h ctl=%b want %h 0000 00000",
                            address, data_out, {wr_en, done, inserted, duplicate, table_full}, BASE);
      end
   endtask

   task automatic test_insert_empty();
      fill(EMPTY);
      run_op(16'h0005, 0, 0, '{lat:17, ins:1, dup:0, full:0, nwr:1, waddr:16'h0008, wdata:16'h0005});
      n_cmp++;
      if (mem[0] !== 16'h0005 || mem[1] !== EMPTY) begin
         n_fail++; $display("FAIL table_after_insert got %h,%h want 0005,ffff", mem[0], mem[1]);
      end
   endtask

   task automatic test_duplicate();
      fill(EMPTY);
      mem[0] = 16'd3; mem[1] = 16'd7; mem[2] = 16'd9;
      run_op(16'h0007, 0, 2, '{lat:2, ins:0, dup:1, full:0, nwr:0, waddr:16'h0, wdata:16'h0});
      fill(EMPTY);
      mem[5] = 16'h0042;
      mem[0] = 16'h0001;
      run_op(16'h0042, 0, 0, '{lat:6, ins:0, dup:1, full:0, nwr:0, waddr:16'h0, wdata:16'h0});
      for (int i = 0; i < 15; i++) mem[i] = 16'h0100 + 16'(i);
      mem[15] = 16'h0BEE;
      run_op(16'h0BEE, 0, 0, '{lat:16, ins:0, dup:1, full:0, nwr:0, waddr:16'h0, wdata:16'h0});
   endtask

   task automatic test_full_and_late_hole();
      for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
      run_op(16'h0020, 0, 1, '{lat:16, ins:0, dup:0, full:1, nwr:0, waddr:16'h0, wdata:16'h0});
      mem[15] = EMPTY;
      run_op(16'h0077, 0, 0, '{lat:17, ins:1, dup:0, full:0, nwr:1, waddr:16'h0026, wdata:16'h0077});
      mem[2] = EMPTY; mem[9] = EMPTY;
      run_op(16'h0033, 0, 0, '{lat:17, ins:1, dup:0, full:0, nwr:1, waddr:16'h000C, wdata:16'h0033});
   endtask

   task automatic test_start_pulse();
      fill(EMPTY);
      mem[0] = 16'd3; mem[1] = 16'd7;
      run_op(16'h0007, 1, 0, '{lat:2, ins:0, dup:1, full:0, nwr:0, waddr:16'h0, wdata:16'h0});
      run_op(16'h0055, 1, 0, '{lat:17, ins:1, dup:0, full:0, nwr:1, waddr:16'h000C, wdata:16'h0055});
   endtask

   task automatic test_empty_id();
      fill(EMPTY);
      run_op(EMPTY, 0, 3, '{lat:1, ins:0, dup:0, full:0, nwr:0, waddr:16'h0, wdata:16'h0});
   endtask

   task automatic test_reset_during_write();
      int cyc;
      fill(EMPTY);
      wr_cnt = 0;
      @(negedge clock);
      sink_id = 16'h0005; start = 1'b1;
      cyc = 0;
      while (wr_en !== 1'b1 && cyc < 40) begin @(posedge clock); #1; cyc++; end
      n_cmp++;
      if (wr_en !== 1'b1) begin
         n_fail++; $display("FAIL write_seen got wr_en=%b want 1", wr_en);
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if (wr_en !== 1'b0 || done !== 1'b0 || address !== BASE || data_out !== 16'h0) begin
         n_fail++; $display("FAIL reset_abort got wr=%b done=%b addr=%h dout=%h want 0 0 %h 0000",
                            wr_en, done, address, data_out, BASE);
      end
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      n_cmp++;
      if (wr_cnt !== 0 || mem[0] !== EMPTY) begin
         n_fail++; $display("FAIL aborted_write got count=%0d mem0=%h want 0 ffff", wr_cnt, mem[0]);
      end
      run_op(16'h0005, 0, 0, '{lat:17, ins:1, dup:0, full:0, nwr:1, waddr:16'h0008, wdata:16'h0005});
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; wr_cnt = 0; wr_addr = '0; wr_data = '0;
      reset = 1'b0; start = 1'b0; sink_id = 16'h0;
      fill(EMPTY);
      #12;
      test_reset();
      @(negedge clock);
      reset = 1'b1;
      test_insert_empty();
      test_duplicate();
      test_full_and_late_hole();
      test_start_pulse();
      test_empty_id();
      test_reset_during_write();
      n_cmp++;
      if (sb.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
